cache_port_arbiter: RTL and testbench
=====================================

CACHE_PORT_ARBITER -- requirements
Module: cache_port_arbiter

Interface
REQ-001 SHALL have parameter NPORT, default 2: number of requester channels, range 1..8.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have a single clock; reset is asynchronous and active-low (ports clk, rstn).
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 p_valid  input  NPORT  per-port request valid.
REQ-008 p_we  input  NPORT  per-port write (1) / read (0).
REQ-009 p_addr  input  NPORT*AW  per-port address; port k at bits [k*AW +: AW].
REQ-010 p_wdata  input  NPORT*DW  per-port write data; port k at [k*DW +: DW].
REQ-011 p_ready  output  NPORT  one-hot accept; request transfers when p_valid[k]&p_ready[k].
REQ-012 p_rvalid  output  NPORT  one-hot, one-cycle completion pulse (read data or write ack).
REQ-013 p_rdata  output  DW  read data shared by all ports, valid when any p_rvalid bit is high.
REQ-014 addr_cache  output  AW  cache address.
REQ-015 wdata_cache  output  DW  cache write data.
REQ-016 rdata_cache  input  DW  cache read data.
REQ-017 write_enable_cache  output  1  cache write strobe.
REQ-018 read_enable_cache  output  1  cache read strobe.
REQ-019 miss_cache  input  1  cache stall; request must be held while high.

Function
REQ-020 SHALL implement FSM states IDLE and BUSY.
REQ-021 IDLE: when any p_valid is high, assert p_ready for exactly one granted port combinationally, latch its addr/wdata/we/index, go to BUSY.
REQ-022 Grant SHALL be round-robin: search starts at (last_grant+1) mod NPORT; last_grant updated on each accept.
REQ-023 p_ready SHALL be all-zero in BUSY and in IDLE with no p_valid.
REQ-024 BUSY: addr_cache/wdata_cache driven from latched values; read_enable_cache = ~we_latched, write_enable_cache = we_latched; exactly one strobe high.
REQ-025 BUSY with miss_cache=0: transaction completes; capture rdata_cache into p_rdata (reads only), pulse p_rvalid[granted] the next cycle, return to IDLE.
REQ-026 BUSY with miss_cache=1: stay BUSY; addr, wdata and strobes held unchanged; any number of miss cycles allowed.
REQ-027 Hit latency: accept at cycle T, strobe high in T+1 only, p_rvalid at T+2; each miss cycle adds one.
REQ-028 IDLE at T+2 SHALL be able to accept a new request in that same cycle as the p_rvalid pulse; max throughput one transaction per 2 cycles.
REQ-029 p_rdata SHALL hold its last captured value until the next read completion; write completions do not modify it.
REQ-030 miss_cache in IDLE SHALL be ignored.
REQ-031 A port whose p_valid drops before grant is not served; no request is queued internally.
REQ-032 Strobes SHALL be 0 in IDLE; addr_cache/wdata_cache keep last values in IDLE.
REQ-033 NPORT=1 SHALL degenerate to pass-through with the same timing.

Reset
REQ-034 rstn low SHALL immediately force: state IDLE, p_ready=0, p_rvalid=0, strobes=0, addr_cache=0, wdata_cache=0, p_rdata=0, last_grant=NPORT-1 (port 0 first priority).
REQ-035 Reset during BUSY SHALL drop the in-flight transaction; no p_rvalid is issued for it after release.

Verification
REQ-036 Single read, NPORT=2: p_valid=01, p_addr[0]=0x100, miss=0, rdata_cache=0xDEADBEEF -> p_ready=01 at T, read_enable_cache=1/addr_cache=0x100 at T+1, p_rvalid=01, p_rdata=0xDEADBEEF at T+2.
REQ-037 Write with miss: port1 we=1 addr=0x200 wdata=0x12345678, miss_cache high 3 cycles -> write_enable_cache high 4 cycles, addr/wdata stable, p_rvalid=10 at T+5, p_rdata unchanged.
REQ-038 Fairness: both ports valid continuously from reset -> grants 0,1,0,1 on accepts at T, T+2, T+4, T+6.
REQ-039 Back-to-back: port0 valid held -> p_rvalid pulse and next p_ready coincide in the same cycle.
REQ-040 Reset mid-miss: assert rstn=0 while BUSY and miss_cache=1 -> all outputs 0 immediately; after release no p_rvalid, next grant goes to port 0.

Source files
------------

// File: rtl/cache_port_arbiter.sv
// Round-robin arbiter funnelling NPORT requester channels into one cache port.
// One transaction in flight at a time; the cache may stall it with miss_cache.
module cache_port_arbiter #(
    parameter int NPORT = 2,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NPORT-1:0]    p_valid,
    input  logic [NPORT-1:0]    p_we,
    input  logic [NPORT*AW-1:0] p_addr,
    input  logic [NPORT*DW-1:0] p_wdata,
    output logic [NPORT-1:0]    p_ready,
    output logic [NPORT-1:0]    p_rvalid,
    output logic [DW-1:0]       p_rdata,
    output logic [AW-1:0]       addr_cache,
    output logic [DW-1:0]       wdata_cache,
    input  logic [DW-1:0]       rdata_cache,
    output logic                write_enable_cache,
    output logic                read_enable_cache,
    input  logic                miss_cache
);

    localparam int LGW = (NPORT > 1) ? $clog2(NPORT) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t         state;
    state_t         state_nxt;
    logic [LGW-1:0] last_grant;
    logic [LGW-1:0] grant_idx;
    logic [LGW-1:0] idx_q;
    logic           grant_any;
    logic           we_q;
    logic           sel_we;
    logic [AW-1:0]  sel_addr;
    logic [DW-1:0]  sel_wdata;
    logic           done;

    assign done = (state == BUSY) && !miss_cache;

    // Search starts one past the last winner so every port gets a turn.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int i = 1; i <= NPORT; i++) begin
            for (int k = 0; k < NPORT; k++) begin
                if (!grant_any && p_valid[k] &&
                    k == (int'(last_grant) + i) % NPORT) begin
                    grant_any = 1'b1;
                    grant_idx = LGW'(k);
                end
            end
        end
    end

    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int k = 0; k < NPORT; k++) begin
            if (grant_idx == LGW'(k)) begin
                sel_we    = p_we[k];
                sel_addr  = p_addr[k*AW +: AW];
                sel_wdata = p_wdata[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (grant_any) state_nxt = BUSY;
            BUSY: if (!miss_cache) state_nxt = IDLE;
        endcase
    end

    // Ready is gated by rstn so it drops the instant reset asserts.
    always_comb begin
        p_ready            = '0;
        write_enable_cache = 1'b0;
        read_enable_cache  = 1'b0;
        for (int k = 0; k < NPORT; k++) begin
            p_ready[k] = rstn && (state == IDLE) && grant_any &&
                         (grant_idx == LGW'(k));
        end
        if (state == BUSY) begin
            write_enable_cache = we_q;
            read_enable_cache  = ~we_q;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant  <= LGW'(NPORT - 1);
            idx_q       <= '0;
            we_q        <= 1'b0;
            addr_cache  <= '0;
            wdata_cache <= '0;
            p_rdata     <= '0;
            p_rvalid    <= '0;
        end else begin
            for (int k = 0; k < NPORT; k++) begin
                p_rvalid[k] <= done && (idx_q == LGW'(k));
            end
            if (state == IDLE && grant_any) begin
                last_grant  <= grant_idx;
                idx_q       <= grant_idx;
                we_q        <= sel_we;
                addr_cache  <= sel_addr;
                wdata_cache <= sel_wdata;
            end
            if (done && !we_q) p_rdata <= rdata_cache;
        end
    end

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter (NPORT=2): read, write with miss,
// fairness, back-to-back and reset during a stalled transaction.
module tb_cache_port_arbiter;

    localparam int NPORT = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NPORT-1:0]  p_valid;
    logic [NPORT-1:0]  p_we;
    logic [AW-1:0]     a0, a1;
    logic [DW-1:0]     w0, w1;
    logic [NPORT*AW-1:0] p_addr;
    logic [NPORT*DW-1:0] p_wdata;
    logic [NPORT-1:0]  p_ready;
    logic [NPORT-1:0]  p_rvalid;
    logic [DW-1:0]     p_rdata;
    logic [AW-1:0]     addr_cache;
    logic [DW-1:0]     wdata_cache;
    logic [DW-1:0]     rdata_cache;
    logic              write_enable_cache;
    logic              read_enable_cache;
    logic              miss_cache;

    int n_tests = 0;
    int n_fail  = 0;

    assign p_addr  = {a1, a0};
    assign p_wdata = {w1, w0};

    always #5 clk = ~clk;

    cache_port_arbiter #(.NPORT(NPORT), .AW(AW), .DW(DW)) dut (
        .clk                (clk),
        .rstn               (rstn),
        .p_valid            (p_valid),
        .p_we               (p_we),
        .p_addr             (p_addr),
        .p_wdata            (p_wdata),
        .p_ready            (p_ready),
        .p_rvalid           (p_rvalid),
        .p_rdata            (p_rdata),
        .addr_cache         (addr_cache),
        .wdata_cache        (wdata_cache),
        .rdata_cache        (rdata_cache),
        .write_enable_cache (write_enable_cache),
        .read_enable_cache  (read_enable_cache),
        .miss_cache         (miss_cache)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    logic [NPORT-1:0] exp_g;

    initial begin
        rstn        = 1'b0;
        p_valid     = 2'b01;
        p_we        = 2'b00;
        a0          = 32'h100;
        a1          = 32'h0;
        w0          = 32'h0;
        w1          = 32'h0;
        miss_cache  = 1'b0;
        rdata_cache = 32'hDEADBEEF;

        // Reset state, with a request already pending
        repeat (2) mid();
        check("rst_ready", p_ready, 0);
        check("rst_rvalid", p_rvalid, 0);
        check("rst_ren", read_enable_cache, 0);
        check("rst_wen", write_enable_cache, 0);
        check("rst_addr", addr_cache, 0);
        check("rst_rdata", p_rdata, 0);

        // Single read on port 0
        step(); rstn = 1'b1;
        mid();  check("rd_ready_T", p_ready, 2'b01);
        step(); p_valid = 2'b00;
        mid();  check("rd_ren_T1", read_enable_cache, 1);
        check("rd_wen_T1", write_enable_cache, 0);
        check("rd_addr_T1", addr_cache, 32'h100);
        check("rd_ready_T1", p_ready, 0);
        step();
        mid();  check("rd_rvalid_T2", p_rvalid, 2'b01);
        check("rd_rdata_T2", p_rdata, 32'hDEADBEEF);
        check("rd_ren_T2", read_enable_cache, 0);

        // Write on port 1 with 3 miss cycles; miss in IDLE is ignored
        step();
        p_valid = 2'b10; p_we = 2'b10; a1 = 32'h200; w1 = 32'h12345678;
        miss_cache = 1'b1; rdata_cache = 32'h55555555;
        check("rd_rvalid_T3", p_rvalid, 0);
        mid();  check("wr_ready_T", p_ready, 2'b10);
        step(); p_valid = 2'b00;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin
                step(); miss_cache = 1'b0;
            end else if (c > 1) begin
                step();
            end
            mid();
            check($sformatf("wr_wen_T%0d", c), write_enable_cache, 1);
            check($sformatf("wr_ren_T%0d", c), read_enable_cache, 0);
            check($sformatf("wr_addr_T%0d", c), addr_cache, 32'h200);
            check($sformatf("wr_wdata_T%0d", c), wdata_cache, 32'h12345678);
            check($sformatf("wr_rvalid_T%0d", c), p_rvalid, 0);
        end
        step();
        mid();  check("wr_rvalid_T5", p_rvalid, 2'b10);
        check("wr_rdata_kept", p_rdata, 32'hDEADBEEF);
        check("wr_wen_T5", write_enable_cache, 0);

        // Fairness from reset: both ports valid continuously
        step(); rstn = 1'b0;
        step(); rstn = 1'b1; p_valid = 2'b11; p_we = 2'b00;
        exp_g = 2'b01;
        mid();  check("rr_ready_0", p_ready, exp_g);
        for (int i = 0; i < 4; i++) begin
            step();
            mid();  check($sformatf("rr_busy_%0d", i), p_ready, 0);
            check($sformatf("rr_ren_%0d", i), read_enable_cache, 1);
            step();
            mid();  check($sformatf("rr_rvalid_%0d", i), p_rvalid, exp_g);
            exp_g = ~exp_g;
            check($sformatf("rr_ready_%0d", i + 1), p_ready, exp_g);
        end
        check("rr_rdata", p_rdata, 32'h55555555);

        // Back-to-back on port 0 alone: completion and next accept coincide
        step(); p_valid = 2'b01;
        for (int i = 0; i < 2; i++) begin
            mid();
            step();
            mid();  check($sformatf("b2b_rvalid_%0d", i), p_rvalid, 2'b01);
            check($sformatf("b2b_ready_%0d", i), p_ready, 2'b01);
            step();
        end

        // Reset during a stalled read
        p_valid = 2'b00;
        step(); step();
        p_valid = 2'b01; a0 = 32'h300; miss_cache = 1'b1;
        mid();  check("mr_ready_T", p_ready, 2'b01);
        step(); p_valid = 2'b00;
        mid();  check("mr_ren_T1", read_enable_cache, 1);
        check("mr_addr_T1", addr_cache, 32'h300);
        #1 rstn = 1'b0; p_valid = 2'b11;
        #1;
        check("mr_rst_ren", read_enable_cache, 0);
        check("mr_rst_wen", write_enable_cache, 0);
        check("mr_rst_addr", addr_cache, 0);
        check("mr_rst_wdata", wdata_cache, 0);
        check("mr_rst_rdata", p_rdata, 0);
        check("mr_rst_rvalid", p_rvalid, 0);
        check("mr_rst_ready", p_ready, 0);
        p_valid = 2'b00;
        step(); rstn = 1'b1; miss_cache = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mid();  check($sformatf("mr_no_rvalid_%0d", i), p_rvalid, 0);
            step();
        end
        p_valid = 2'b11;
        mid();  check("mr_next_grant", p_ready, 2'b01);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
